// File: rtl/controller_nes_responder.sv
// NES pad responder: samples a debounced button vector on latch and shifts it out
// on pulse rising edges as active-low serial data, counting completed frames.
module controller_nes_responder #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned POLL_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              latch_in,
  input  logic              pulse_in,
  input  logic [0:7]        buttons_in,
  output logic              data_out,
  output logic              frame_strobe,
  output logic              busy,
  output logic [POLL_W-1:0] poll_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                   state, state_nx;
  logic [0:7]               shreg, shreg_nx;
  logic [3:0]               bit_idx, bit_idx_nx;
  logic                     strobe_nx, data_nx;
  logic [POLL_W-1:0]        count_nx;
  logic [0:7]               db;

  logic [SYNC_STAGES-1:0]   latch_sync, pulse_sync;
  logic                     latch_hist, pulse_hist;
  logic                     latch_cur, pulse_cur;
  logic                     latch_rise, latch_fall, pulse_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      latch_hist <= 1'b0;
      pulse_hist <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pulse_in};
      latch_hist <= latch_cur;
      pulse_hist <= pulse_cur;
    end
  end

  assign latch_cur  = latch_sync[SYNC_STAGES-1];
  assign pulse_cur  = pulse_sync[SYNC_STAGES-1];
  assign latch_rise = latch_cur & ~latch_hist;
  assign latch_fall = ~latch_cur & latch_hist;
  assign pulse_rise = pulse_cur & ~pulse_hist;

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_db_bypass
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) db <= '0;
        else      db <= buttons_in;
      end
    end else begin : g_db
      localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CW-1:0] cnt [8];
      logic [0:7]    cand;

      // A bit is accepted once its candidate has matched the raw input for
      // DEBOUNCE_CYCLES consecutive samples; any disagreement restarts the count.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cand <= '0;
          db   <= '0;
          for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (buttons_in[i] != cand[i]) begin
              cand[i] <= buttons_in[i];
              cnt[i]  <= '0;
            end else if (cnt[i] != CW'(DEBOUNCE_CYCLES)) begin
              cnt[i] <= cnt[i] + CW'(1);
            end else begin
              db[i] <= cand[i];
            end
          end
        end
      end
    end
  endgenerate

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_idx_nx = bit_idx;
    strobe_nx  = 1'b0;
    count_nx   = poll_count;
    case (state)
      IDLE: begin
        if (latch_rise) begin
          state_nx   = LOAD;
          shreg_nx   = db;
          bit_idx_nx = '0;
        end
      end
      LOAD: begin
        shreg_nx   = db;
        bit_idx_nx = '0;
        if (latch_fall) begin
          state_nx = SHIFT;
          shreg_nx = shreg;
        end
      end
      SHIFT: begin
        // Latch has priority: a coincident pulse edge is dropped.
        if (latch_rise) begin
          state_nx   = LOAD;
          shreg_nx   = db;
          bit_idx_nx = '0;
        end else if (pulse_rise) begin
          shreg_nx   = {shreg[1:7], 1'b0};
          bit_idx_nx = bit_idx + 4'd1;
          if (bit_idx == 4'd7) begin
            state_nx  = DONE;
            strobe_nx = 1'b1;
            count_nx  = poll_count + POLL_W'(1);
          end
        end
      end
      DONE: begin
        if (latch_rise) begin
          state_nx   = LOAD;
          shreg_nx   = db;
          bit_idx_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    data_nx = ((state_nx == LOAD) || (state_nx == SHIFT)) ? ~shreg_nx[0] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_idx      <= '0;
      data_out     <= 1'b1;
      frame_strobe <= 1'b0;
      poll_count   <= '0;
    end else begin
      state        <= state_nx;
      shreg        <= shreg_nx;
      bit_idx      <= bit_idx_nx;
      data_out     <= data_nx;
      frame_strobe <= strobe_nx;
      poll_count   <= count_nx;
    end
  end

  assign busy = (state == LOAD) || (state == SHIFT);

endmodule
